// File: rtl/dac_sample_bridge.sv
// Multi-channel DSP-to-DAC sample bridge: assembles channel-tagged input beats into
// whole frames in a frame FIFO and replays one frame per DAC rate tick with a soft-mute ramp.
module dac_sample_bridge #(
   parameter int DW         = 24,
   parameter int NUM_CH     = 2,
   parameter int DEPTH      = 4,
   parameter int ATT_MAX    = 16,
   parameter int UNDER_MODE = 0,
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int PW = $clog2(DEPTH),
   localparam int FW = PW + 1,
   localparam int AW = $clog2(ATT_MAX + 1)
) (
   input  logic          m_clk,
   input  logic          rst,
   input  logic [DW-1:0] s_data,
   input  logic [CW-1:0] s_ch,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic          rate_tick,
   input  logic          mute,
   output logic [DW-1:0] dac_data,
   output logic [CW-1:0] dac_ch,
   output logic          dac_valid,
   output logic          muted,
   output logic          underrun,
   output logic          overrun,
   output logic          sync_err,
   output logic [FW-1:0] fill,
   output logic          dbg_state
);

   typedef enum logic {IDLE, SEND} state_t;
   typedef logic [NUM_CH-1:0][DW-1:0] frame_t;

   state_t               state, state_nx;
   frame_t               mem [DEPTH];
   frame_t               last_frame;
   frame_t               src_frame;
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        exp_ch;
   logic [CW-1:0]        k;
   logic                 src_fifo;
   logic [AW-1:0]        att, att_frame;
   logic signed [DW-1:0] sample_s;
   logic signed [DW-1:0] shifted;

   logic accept, ch_ok, commit, final_beat, pop, tick_go, wr_en;

   // Handshake: a beat is taken on every cycle with s_valid && s_ready; s_ready depends
   // only on the committed fill level, never on s_valid, so the producer may hold data.
   assign s_ready    = (fill < FW'(DEPTH));
   assign accept     = s_valid & s_ready;
   assign ch_ok      = (s_ch == exp_ch);
   assign commit     = accept & ch_ok & (s_ch == CW'(NUM_CH - 1));
   assign wr_en      = accept & (ch_ok | (s_ch == '0));
   assign final_beat = (state == SEND) & (k == CW'(NUM_CH - 1));
   assign pop        = final_beat & src_fifo;
   assign tick_go    = rate_tick & (state == IDLE);

   assign underrun  = ~rst & tick_go & (fill == '0);
   assign overrun   = ~rst & rate_tick & (state == SEND);
   assign sync_err  = ~rst & accept & ~ch_ok;
   assign muted     = (att == AW'(ATT_MAX));
   assign dbg_state = (state == SEND);

   // The source frame stays stable for the whole frame: the head slot is not reused
   // until its pop, and last_frame only changes on the final beat.
   always_comb begin
      if (src_fifo)             src_frame = mem[rd_ptr];
      else if (UNDER_MODE != 0) src_frame = last_frame;
      else                      src_frame = '0;
   end

   assign sample_s = src_frame[k];
   assign shifted  = sample_s >>> att_frame;

   always_comb begin
      state_nx  = state;
      dac_valid = 1'b0;
      dac_ch    = '0;
      dac_data  = '0;
      case (state)
         IDLE: begin
            if (rate_tick) state_nx = SEND;
         end
         SEND: begin
            dac_valid = 1'b1;
            dac_ch    = k;
            dac_data  = (att_frame == AW'(ATT_MAX)) ? '0 : shifted;
            if (final_beat) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge m_clk) begin
      if (rst) begin
         state      <= IDLE;
         k          <= '0;
         src_fifo   <= 1'b0;
         att        <= '0;
         att_frame  <= '0;
         last_frame <= '0;
         exp_ch     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill       <= '0;
      end else begin
         state <= state_nx;

         // att is captured for the frame first, then stepped toward the mute target.
         if (tick_go) begin
            k         <= '0;
            src_fifo  <= (fill != '0);
            att_frame <= att;
            if (mute && att != AW'(ATT_MAX)) att <= att + 1'b1;
            else if (!mute && att != '0)     att <= att - 1'b1;
         end else if (state == SEND && !final_beat) begin
            k <= k + 1'b1;
         end

         if (final_beat) begin
            last_frame <= src_frame;
            if (src_fifo) rd_ptr <= rd_ptr + 1'b1;
         end

         // A mismatched channel 0 restarts the frame; any other mismatch waits for channel 0.
         if (accept) begin
            if (ch_ok)              exp_ch <= commit ? '0 : exp_ch + 1'b1;
            else if (s_ch == '0)    exp_ch <= CW'(1);
            else                    exp_ch <= '0;
         end
         if (commit) wr_ptr <= wr_ptr + 1'b1;

         case ({commit, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   always_ff @(posedge m_clk) begin
      if (!rst && wr_en) mem[wr_ptr][s_ch] <= s_data;
   end

endmodule
